// File: rtl/video_pll_pkg.sv
// rtl/video_pll_pkg.sv - shared types and defaults for the video PLL supervisor
//
// Purpose: FSM state encoding (also exposed on state_o), pixel-clock mux
// select encodings and default timing constants.
// Ports: none (package).

package video_pll_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_ENABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_SWITCH    = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [1:0] SEL_20M  = 2'd0;
  localparam logic [1:0] SEL_25M  = 2'd1;
  localparam logic [1:0] SEL_33M  = 2'd2;
  // Encoding 3 selects nothing; requests for it are accepted and dropped.
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_SWITCH_GAP_CYCLES   = 8;
  localparam int DEF_DS_RST_DELAY        = 64;
  localparam int DEF_MAX_RETRIES         = 3;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer
//
// Purpose: bring an asynchronous level into the i_clk domain (2-cycle latency).
// Ports:
//   i_clk    in  clock of the destination domain
//   i_rst_n  in  asynchronous active-low reset, both stages clear to 0
//   i_d      in  asynchronous input
//   o_q      out synchronized output

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/video_pll_supervisor.sv
// rtl/video_pll_supervisor.sv - reset sequencer and lock supervisor for the video PLL
//
// Purpose: pulses the PLL reset, qualifies lock, enables the pixel-clock mux,
// releases the downstream reset after a delay, handles clock-select changes
// and loss-of-lock recovery with bounded retries. Single clock domain (refclk).
// Ports:
//   refclk           in  50 MHz reference clock
//   rst_n            in  asynchronous active-low reset
//   pll_locked_async in  PLL lock, asynchronous
//   pll_rst          out active-high PLL reset
//   clk_en           out pixel-clock mux enable
//   clk_sel          out pixel-clock select (SEL_20M/SEL_25M/SEL_33M)
//   ds_rst_n         out downstream video reset, active low
//   mode_req_valid   in  clock-select change request
//   mode_req         in  requested clk_sel
//   mode_req_ready   out request accepted this cycle
//   clear_fault      in  pulse to leave FAULT
//   state_o          out FSM state
//   retry_count      out PLL reset attempts used in this bring-up
//   lock_loss_count  out saturating count of lock losses in RUN
//   fault            out high in FAULT

module video_pll_supervisor
  import video_pll_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int SWITCH_GAP_CYCLES   = DEF_SWITCH_GAP_CYCLES,
  parameter int DS_RST_DELAY        = DEF_DS_RST_DELAY,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked_async,
  output logic       pll_rst,
  output logic       clk_en,
  output logic [1:0] clk_sel,
  output logic       ds_rst_n,
  input  logic       mode_req_valid,
  input  logic [1:0] mode_req,
  output logic       mode_req_ready,
  input  logic       clear_fault,
  output logic [2:0] state_o,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic       fault
);

  localparam int MAX_T = max_of(max_of(max_of(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                       max_of(LOCK_STABLE_CYCLES, SWITCH_GAP_CYCLES)),
                                DS_RST_DELAY);
  localparam int CNT_W = $clog2(MAX_T) + 1;

  // Terminal counts: the counter starts at 0 on state entry, so a state that
  // must last N cycles leaves when the counter shows N-1.
  localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_LAST = CNT_W'(SWITCH_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GAP_MID  = CNT_W'(SWITCH_GAP_CYCLES / 2);
  localparam logic [CNT_W-1:0] C_DS_LAST  = CNT_W'(DS_RST_DELAY - 1);
  localparam logic [1:0]       C_RETRY_LAST = 2'(MAX_RETRIES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lock_s;
  logic [1:0]       r_pending_sel;
  logic [1:0]       r_retry;
  logic [7:0]       r_loss_cnt;
  logic             r_pll_rst;
  logic             r_clk_en;
  logic [1:0]       r_clk_sel;
  logic             r_ds_rst_n;
  logic             r_fault;

  logic w_ready;
  logic w_retry_inc;
  logic w_retry_clr;
  logic w_loss_inc;
  logic w_pend_load;
  logic w_sel_apply;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked_async),
    .o_q     (w_lock_s)
  );

  // Built only from flops: ready drops in the same cycle a lock loss is seen,
  // so a coincident request is never taken.
  assign w_ready = (r_state == ST_RUN) && w_lock_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET_PLL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_loss_inc  = 1'b0;
    w_pend_load = 1'b0;
    w_sel_apply = 1'b0;
    case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABILIZE;
        end else if (r_cnt == C_TO_LAST) begin
          if (r_retry == C_RETRY_LAST) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_retry_inc = 1'b1;
            w_state_nxt = ST_RESET_PLL;
          end
        end
      end
      ST_STABILIZE: begin
        // Dropping back clears the counter, so the lock timeout restarts.
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == C_STB_LAST) begin
          w_state_nxt = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (r_cnt == C_DS_LAST) begin
          w_retry_clr = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_loss_inc  = 1'b1;
          w_state_nxt = ST_RESET_PLL;
        end else if (mode_req_valid && w_ready && (mode_req != SEL_NONE)) begin
          w_pend_load = 1'b1;
          w_state_nxt = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        // clk_en is already low here, so applying the select early on a
        // lock loss is safe and leaves the requested clock for the re-bring-up.
        if (!w_lock_s) begin
          w_sel_apply = 1'b1;
          w_state_nxt = ST_RESET_PLL;
        end else begin
          if (r_cnt == C_GAP_MID) w_sel_apply = 1'b1;
          if (r_cnt == C_GAP_LAST) w_state_nxt = ST_ENABLE;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          w_retry_clr = 1'b1;
          w_state_nxt = ST_RESET_PLL;
        end
      end
      default: w_state_nxt = ST_RESET_PLL;
    endcase
  end

  // Shared timer: cleared on every state change, idle in RUN and FAULT.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state != ST_RUN && r_state != ST_FAULT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry       <= 2'd0;
      r_loss_cnt    <= 8'd0;
      r_pending_sel <= SEL_25M;
    end else begin
      if (w_retry_clr) begin
        r_retry <= 2'd0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 2'd1;
      end
      if (w_loss_inc && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
      if (w_pend_load) r_pending_sel <= mode_req;
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst  <= 1'b1;
      r_clk_en   <= 1'b0;
      r_clk_sel  <= SEL_25M;
      r_ds_rst_n <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_pll_rst  <= (w_state_nxt == ST_RESET_PLL);
      r_clk_en   <= (w_state_nxt == ST_ENABLE) || (w_state_nxt == ST_RUN);
      r_ds_rst_n <= (w_state_nxt == ST_RUN);
      r_fault    <= (w_state_nxt == ST_FAULT);
      if (w_sel_apply) r_clk_sel <= r_pending_sel;
    end
  end

  assign pll_rst         = r_pll_rst;
  assign clk_en          = r_clk_en;
  assign clk_sel         = r_clk_sel;
  assign ds_rst_n        = r_ds_rst_n;
  assign mode_req_ready  = w_ready;
  assign state_o         = r_state;
  assign retry_count     = r_retry;
  assign lock_loss_count = r_loss_cnt;
  assign fault           = r_fault;

endmodule

// File: tb/tb_video_pll_supervisor.sv
// tb/tb_video_pll_supervisor.sv - scoreboard bench for video_pll_supervisor

module tb_video_pll_supervisor;

  localparam int P_RST  = 16;
  localparam int P_TO   = 200;
  localparam int P_STB  = 64;
  localparam int P_GAP  = 8;
  localparam int P_DS   = 16;
  localparam int P_MAXR = 3;

  localparam int K_PLLRST = 0;
  localparam int K_ST_EQ  = 1;
  localparam int K_EN_PRE = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked_async = 1'b0;
  logic       mode_req_valid = 1'b0;
  logic [1:0] mode_req = 2'd0;
  logic       clear_fault = 1'b0;
  logic       pll_rst;
  logic       clk_en;
  logic [1:0] clk_sel;
  logic       ds_rst_n;
  logic       mode_req_ready;
  logic [2:0] state_o;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;
  logic       fault;

  always #5 refclk = ~refclk;

  video_pll_supervisor #(
    .RST_PULSE_CYCLES    (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .LOCK_STABLE_CYCLES  (P_STB),
    .SWITCH_GAP_CYCLES   (P_GAP),
    .DS_RST_DELAY        (P_DS),
    .MAX_RETRIES         (P_MAXR)
  ) dut (
    .refclk           (refclk),
    .rst_n            (rst_n),
    .pll_locked_async (pll_locked_async),
    .pll_rst          (pll_rst),
    .clk_en           (clk_en),
    .clk_sel          (clk_sel),
    .ds_rst_n         (ds_rst_n),
    .mode_req_valid   (mode_req_valid),
    .mode_req         (mode_req),
    .mode_req_ready   (mode_req_ready),
    .clear_fault      (clear_fault),
    .state_o          (state_o),
    .retry_count      (retry_count),
    .lock_loss_count  (lock_loss_count),
    .fault            (fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input int got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  function automatic bit cond(input int code, input int arg);
    case (code)
      K_PLLRST: return pll_rst == 1'b1;
      K_ST_EQ:  return int'(state_o) == arg;
      K_EN_PRE: return clk_en && !ds_rst_n;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic count_while(input string tag, input int code, input int arg,
                             input int budget, output int n);
    n = 0;
    while (cond(code, arg) && n < budget) begin
      n++;
      @(negedge refclk);
    end
    if (n >= budget) check({tag, "_bound"}, 0, 1);
  endtask

  task automatic wait_until(input string tag, input int code, input int arg,
                            input int budget);
    int n;
    n = 0;
    while (!cond(code, arg) && n < budget) begin
      n++;
      @(negedge refclk);
    end
    if (n >= budget) check({tag, "_bound"}, 0, 1);
  endtask

  // Invariants watched all run long: ds_rst_n only after DS_RST_DELAY
  // cycles of clk_en, and clk_sel never moves while clk_en is high.
  int         en_run = 0;
  int         viol = 0;
  logic [1:0] prev_sel = 2'd1;

  always @(negedge refclk) begin
    if ((ds_rst_n && !(clk_en && en_run >= P_DS)) || (clk_en && clk_sel != prev_sel))
      viol <= viol + 1;
    en_run   <= clk_en ? en_run + 1 : 0;
    prev_sel <= clk_sel;
  end

  task automatic push_reset_values(input string pfx);
    sb_push({pfx, "_pll_rst"}, 1);
    sb_push({pfx, "_clk_en"}, 0);
    sb_push({pfx, "_clk_sel"}, 1);
    sb_push({pfx, "_ds_rst_n"}, 0);
    sb_push({pfx, "_ready"}, 0);
    sb_push({pfx, "_retry"}, 0);
    sb_push({pfx, "_loss"}, 0);
    sb_push({pfx, "_fault"}, 0);
    sb_push({pfx, "_state"}, 0);
  endtask

  task automatic pop_reset_values();
    sb_pop_check(pll_rst);
    sb_pop_check(clk_en);
    sb_pop_check(clk_sel);
    sb_pop_check(ds_rst_n);
    sb_pop_check(mode_req_ready);
    sb_pop_check(retry_count);
    sb_pop_check(lock_loss_count);
    sb_pop_check(fault);
    sb_pop_check(state_o);
  endtask

  initial begin
    int n;
    int cyc;
    int rises;
    int idx;
    logic prev_rst;

    // Reset state
    repeat (3) @(negedge refclk);
    push_reset_values("rst");
    pop_reset_values();

    // Nominal bring-up, lock 100 cycles after pll_rst falls
    rst_n = 1'b1;
    sb_push("pll_rst_len", P_RST);
    count_while("pll_rst_len", K_PLLRST, 0, 1000, n);
    sb_pop_check(n);
    repeat (100) @(negedge refclk);
    pll_locked_async = 1'b1;
    wait_until("to_stab", K_ST_EQ, 2, 20);
    sb_push("stab_len", P_STB);
    count_while("stab_len", K_ST_EQ, 2, 1000, n);
    sb_pop_check(n);
    sb_push("en_to_ds", P_DS);
    count_while("en_to_ds", K_EN_PRE, 0, 1000, n);
    sb_pop_check(n);
    sb_push("up_state", 4);
    sb_push("up_clk_sel", 1);
    sb_push("up_retry", 0);
    sb_push("up_ds_rst_n", 1);
    sb_pop_check(state_o);
    sb_pop_check(clk_sel);
    sb_pop_check(retry_count);
    sb_pop_check(ds_rst_n);

    // Lock never asserts: three attempts, then FAULT
    rst_n = 1'b0;
    pll_locked_async = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    sb_push("rst_pulses", P_MAXR);
    sb_push("fault_time", P_MAXR * (P_RST + P_TO));
    cyc = 0;
    rises = 0;
    prev_rst = 1'b1;
    while (state_o != 3'd6 && cyc < 5000) begin
      if (pll_rst && !prev_rst) rises++;
      prev_rst = pll_rst;
      cyc++;
      @(negedge refclk);
    end
    if (cyc >= 5000) check("fault_wait_bound", 0, 1);
    sb_pop_check(rises + 1);
    sb_pop_check(cyc);
    sb_push("f_fault", 1);
    sb_push("f_ds_rst_n", 0);
    sb_push("f_clk_en", 0);
    sb_push("f_pll_rst", 0);
    sb_push("f_retry", P_MAXR - 1);
    sb_pop_check(fault);
    sb_pop_check(ds_rst_n);
    sb_pop_check(clk_en);
    sb_pop_check(pll_rst);
    sb_pop_check(retry_count);
    clear_fault = 1'b1;
    @(negedge refclk);
    clear_fault = 1'b0;
    sb_push("clr_state", 0);
    sb_push("clr_retry", 0);
    sb_push("clr_fault", 0);
    sb_push("clr_pll_rst", 1);
    sb_pop_check(state_o);
    sb_pop_check(retry_count);
    sb_pop_check(fault);
    sb_pop_check(pll_rst);

    // One-cycle lock glitch inside STABILIZE
    wait_until("g_wait", K_ST_EQ, 1, 100);
    pll_locked_async = 1'b1;
    wait_until("g_stab", K_ST_EQ, 2, 10);
    repeat (30) @(negedge refclk);
    pll_locked_async = 1'b0;
    @(negedge refclk);
    pll_locked_async = 1'b1;
    wait_until("g_back", K_ST_EQ, 1, 10);
    sb_push("g_wait_len", 1);
    count_while("g_wait_len", K_ST_EQ, 1, 100, n);
    sb_pop_check(n);
    sb_push("g_stab_len", P_STB);
    count_while("g_stab_len", K_ST_EQ, 2, 1000, n);
    sb_pop_check(n);
    sb_push("g_en_to_ds", P_DS);
    count_while("g_en_to_ds", K_EN_PRE, 0, 1000, n);
    sb_pop_check(n);
    sb_push("g_state", 4);
    sb_push("g_retry", 0);
    sb_pop_check(state_o);
    sb_pop_check(retry_count);

    // Mode switch to outclk2
    mode_req = 2'd2;
    mode_req_valid = 1'b1;
    sb_push("sw_ready", 1);
    sb_pop_check(mode_req_ready);
    @(negedge refclk);
    mode_req_valid = 1'b0;
    sb_push("sw_state", 5);
    sb_push("sw_clk_en", 0);
    sb_push("sw_ds_rst_n", 0);
    sb_pop_check(state_o);
    sb_pop_check(clk_en);
    sb_pop_check(ds_rst_n);
    sb_push("sw_gap_len", P_GAP);
    idx = -1;
    n = 0;
    while (state_o == 3'd5 && n < 100) begin
      if (idx < 0 && clk_sel == 2'd2) idx = n;
      n++;
      @(negedge refclk);
    end
    sb_pop_check(n);
    check("sw_sel_mid_gap", int'(idx >= P_GAP / 2 && idx <= P_GAP / 2 + 1), 1);
    sb_push("sw_en_to_ds", P_DS);
    count_while("sw_en_to_ds", K_EN_PRE, 0, 1000, n);
    sb_pop_check(n);
    sb_push("sw_run_state", 4);
    sb_push("sw_clk_sel", 2);
    sb_pop_check(state_o);
    sb_pop_check(clk_sel);

    // Request for encoding 3 is accepted and ignored
    mode_req = 2'd3;
    mode_req_valid = 1'b1;
    sb_push("m3_ready", 1);
    sb_pop_check(mode_req_ready);
    @(negedge refclk);
    mode_req_valid = 1'b0;
    sb_push("m3_state", 4);
    sb_push("m3_clk_sel", 2);
    sb_push("m3_clk_en", 1);
    sb_pop_check(state_o);
    sb_pop_check(clk_sel);
    sb_pop_check(clk_en);

    // Lock loss coinciding with a request
    pll_locked_async = 1'b0;
    repeat (2) @(negedge refclk);
    mode_req = 2'd0;
    mode_req_valid = 1'b1;
    sb_push("ll_ready", 0);
    sb_push("ll_state_pre", 4);
    sb_pop_check(mode_req_ready);
    sb_pop_check(state_o);
    @(negedge refclk);
    mode_req_valid = 1'b0;
    sb_push("ll_state", 0);
    sb_push("ll_count", 1);
    sb_push("ll_clk_en", 0);
    sb_push("ll_ds_rst_n", 0);
    sb_push("ll_clk_sel", 2);
    sb_pop_check(state_o);
    sb_pop_check(lock_loss_count);
    sb_pop_check(clk_en);
    sb_pop_check(ds_rst_n);
    sb_pop_check(clk_sel);
    wait_until("ll_wait", K_ST_EQ, 1, 50);
    pll_locked_async = 1'b1;
    wait_until("ll_run", K_ST_EQ, 4, 500);
    sb_push("ll_rerun_state", 4);
    sb_push("ll_rerun_sel", 2);
    sb_pop_check(state_o);
    sb_pop_check(clk_sel);

    // 300 losses in total saturate the counter
    sb_push("loss_sat", 255);
    for (int k = 1; k < 300; k++) begin
      pll_locked_async = 1'b0;
      wait_until("sat_rst", K_ST_EQ, 0, 10);
      wait_until("sat_wait", K_ST_EQ, 1, 50);
      pll_locked_async = 1'b1;
      wait_until("sat_run", K_ST_EQ, 4, 500);
    end
    sb_pop_check(lock_loss_count);

    // Asynchronous reset in the middle of SWITCH
    mode_req = 2'd0;
    mode_req_valid = 1'b1;
    @(negedge refclk);
    mode_req_valid = 1'b0;
    repeat (3) @(negedge refclk);
    sb_push("ar_in_switch", 5);
    sb_pop_check(state_o);
    #2;
    rst_n = 1'b0;
    #1;
    push_reset_values("ar");
    pop_reset_values();

    @(negedge refclk);
    check("invariants", viol, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
